wb_spraid_ctrl: RTL and testbench

WB_SPRAID_CTRL -- requirements
Module: wb_spraid_ctrl

---
 rtl/wb_spraid_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_wb_spraid_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spraid_ctrl.sv
// wb_spraid_ctrl: Wishbone slave in front of a SPI RAID core.
// Forwards a 2**MEM_AW word window to the core, holds a small CSR block
// (RAID_TYPE, STATUS, CHAN_EN, ERR_CNT, TMO) and bounds core waits.
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset;
//   wb_* Wishbone slave; core_* request/response pair to the core;
//   raid_type_o, chan_en_o configuration for the core.
module wb_spraid_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          MEM_AW    = 10,
  parameter int          NCH       = 4,
  parameter int          TMO_W     = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic              wb_stall_o,
  output logic              core_req_o,
  output logic              core_we_o,
  output logic [MEM_AW-1:0] core_adr_o,
  output logic [31:0]       core_dat_o,
  output logic [3:0]        core_sel_o,
  output logic [3:0]        raid_type_o,
  output logic [NCH-1:0]    chan_en_o,
  input  logic              core_gnt_i,
  input  logic              core_done_i,
  input  logic [31:0]       core_dat_i,
  input  logic              core_err_i,
  input  logic              core_parity_i,
  input  logic              core_busy_i
);

  localparam logic [31:0] REG_BASE =
    BASE_ADDR + (32'd1 << MEM_AW);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t state, state_d;

  logic [TMO_W-1:0] tmo, tmo_cnt;
  logic [15:0] err_cnt;
  logic err_sticky, tmo_sticky;
  logic dropped, drop_d;
  logic ack_d, err_d, rty_d, tmo_set;
  logic [31:0] reg_off, rd_data;
  logic mem_hit, reg_hit, take;
  logic reg_wr, mem_go;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = sel[i] ? nw[8*i +: 8]
                           : old[8*i +: 8];
    return r;
  endfunction

  assign reg_off = wb_adr_i - REG_BASE;
  assign mem_hit = (wb_adr_i >= BASE_ADDR) &&
                   (wb_adr_i < REG_BASE);
  assign reg_hit = (wb_adr_i >= REG_BASE) &&
                   (reg_off < 32'd5);
  assign take    = (state == IDLE) &&
                   wb_cyc_i && wb_stb_i;
  assign reg_wr  = take && reg_hit && wb_we_i;
  assign mem_go  = take && mem_hit &&
                   (chan_en_o != '0);

  assign wb_stall_o = (state != IDLE);
  assign core_req_o = (state == REQ);

  // A master that lets go of cyc while the core
  // is busy gets no response, but the core still
  // has to finish (or time out) before IDLE.
  assign drop_d = dropped | ~wb_cyc_i;

  always_comb begin
    state_d = state;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    tmo_set = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          state_d = RESP;
          if (reg_hit)
            ack_d = 1'b1;
          else if (!mem_hit)
            err_d = 1'b1;
          else if (chan_en_o == '0)
            rty_d = 1'b1;
          else
            state_d = REQ;
        end
      end
      REQ: begin
        if (core_gnt_i)
          state_d = WAIT;
        else if (!wb_cyc_i)
          state_d = IDLE;
      end
      WAIT: begin
        // done wins over a coincident timeout
        if (core_done_i || tmo_cnt == tmo) begin
          state_d = drop_d ? IDLE : RESP;
          if (!drop_d) begin
            ack_d   = core_done_i & ~core_err_i;
            err_d   = ~(core_done_i & ~core_err_i);
            tmo_set = ~core_done_i;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (reg_off[2:0])
      3'd0: rd_data = 32'(raid_type_o);
      3'd1: rd_data = {28'd0, tmo_sticky,
                       core_parity_i, err_sticky,
                       core_busy_i};
      3'd2: rd_data = 32'(chan_en_o);
      3'd3: rd_data = {16'd0, err_cnt};
      3'd4: rd_data = 32'(tmo);
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      dropped  <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_d;
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
      wb_rty_o <= rty_d;
      dropped  <= (state_d == WAIT) & drop_d;
      tmo_cnt  <= (state == WAIT)
                ? tmo_cnt + TMO_W'(1) : '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_dat_o   <= '0;
      core_we_o  <= 1'b0;
      core_adr_o <= '0;
      core_dat_o <= '0;
      core_sel_o <= '0;
    end else begin
      if (take && reg_hit && !wb_we_i)
        wb_dat_o <= rd_data;
      else if (state == WAIT && ack_d)
        wb_dat_o <= core_dat_i;
      if (mem_go) begin
        core_we_o  <= wb_we_i;
        core_adr_o <= wb_adr_i[MEM_AW-1:0] -
                      BASE_ADDR[MEM_AW-1:0];
        core_dat_o <= wb_dat_i;
        core_sel_o <= wb_sel_i;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      raid_type_o <= 4'd1;
      chan_en_o   <= '1;
      tmo         <= '1;
      err_cnt     <= '0;
      err_sticky  <= 1'b0;
      tmo_sticky  <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (reg_off[2:0])
          3'd0: raid_type_o <= 4'(merge(
                  32'(raid_type_o),
                  wb_dat_i, wb_sel_i));
          3'd1: begin
            err_sticky <= 1'b0;
            tmo_sticky <= 1'b0;
          end
          3'd2: chan_en_o <= NCH'(merge(
                  32'(chan_en_o),
                  wb_dat_i, wb_sel_i));
          3'd3: err_cnt <= '0;
          3'd4: tmo <= TMO_W'(merge(
                  32'(tmo),
                  wb_dat_i, wb_sel_i));
          default: ;
        endcase
      end
      if (tmo_set)
        tmo_sticky <= 1'b1;
      if (wb_err_o) begin
        err_sticky <= 1'b1;
        if (err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_spraid_ctrl.sv
// tb_wb_spraid_ctrl: directed bench for wb_spraid_ctrl.
// CSR vectors from a table, core handshakes as hand sequences.
module tb_wb_spraid_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] R    = 32'h3000_0400;
  localparam logic [2:0]  ACK  = 3'b100;
  localparam logic [2:0]  ERR  = 3'b010;
  localparam logic [2:0]  RTY  = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 0, stb = 0, we = 0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dato;
  logic ack, err, rty, stall;
  logic core_req, core_we;
  logic [9:0]  core_adr;
  logic [31:0] core_dat;
  logic [3:0]  core_sel, raid_type;
  logic [3:0]  chan_en;
  logic gnt = 0, done = 0, cerr = 0;
  logic par = 0, busy = 0;
  logic [31:0] cdat = '0;

  always #5 clk = ~clk;

  wb_spraid_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb_cyc_i     (cyc),
    .wb_stb_i     (stb),
    .wb_we_i      (we),
    .wb_adr_i     (adr),
    .wb_dat_i     (wdat),
    .wb_sel_i     (sel),
    .wb_dat_o     (dato),
    .wb_ack_o     (ack),
    .wb_err_o     (err),
    .wb_rty_o     (rty),
    .wb_stall_o   (stall),
    .core_req_o   (core_req),
    .core_we_o    (core_we),
    .core_adr_o   (core_adr),
    .core_dat_o   (core_dat),
    .core_sel_o   (core_sel),
    .raid_type_o  (raid_type),
    .chan_en_o    (chan_en),
    .core_gnt_i   (gnt),
    .core_done_i  (done),
    .core_dat_i   (cdat),
    .core_err_i   (cerr),
    .core_parity_i(par),
    .core_busy_i  (busy)
  );

  int tests = 0, fails = 0;
  int n_ack = 0, n_err = 0;
  int n_rty = 0, n_req = 0;

  always @(negedge clk) begin
    if (ack) n_ack++;
    if (err) n_err++;
    if (rty) n_rty++;
    if (core_req) n_req++;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Wishbone access; returns response bits,
  // data, edges to response, stall-low samples.
  task automatic bus(input logic w,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] s,
                     output logic [2:0] rsp,
                     output logic [31:0] rd,
                     output int lat,
                     output int nst);
    cyc = 1; stb = 1; we = w;
    adr = a; wdat = d; sel = s;
    lat = 0; nst = 0;
    rsp = '0; rd = '0;
    while (rsp == 3'b000 && lat < 40) begin
      tick();
      lat++;
      rsp = {ack, err, rty};
      rd = dato;
      if (!stall) nst++;
    end
    cyc = 0; stb = 0; we = 0;
    tick();
  endtask

  task automatic core_resp(input int gd,
                           input int dd,
                           input logic dodone,
                           input logic [31:0] d,
                           input logic e,
                           input logic xwe,
                           input logic [9:0] xadr,
                           input logic [31:0] xdat,
                           input logic [3:0] xsel);
    int k = 0;
    while (!core_req && k < 8) begin
      tick();
      k++;
    end
    check("core_req", core_req, 1);
    check("core_we", core_we, xwe);
    check("core_adr", core_adr, xadr);
    check("core_dat", core_dat, xdat);
    check("core_sel", core_sel, xsel);
    repeat (gd) tick();
    gnt = 1;
    tick();
    gnt = 0;
    if (dodone) begin
      repeat (dd) tick();
      done = 1; cdat = d; cerr = e;
      tick();
      done = 0; cerr = 0;
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        par;
    logic [2:0]  rsp;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic w, input logic [31:0] a,
    input logic [31:0] d, input logic [3:0] s,
    input logic p, input logic [2:0] r,
    input logic [31:0] x);
    vec_t v;
    v.we = w; v.adr = a; v.dat = d;
    v.sel = s; v.par = p; v.rsp = r;
    v.rdat = x;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] rsp;
    logic [31:0] rd, last;
    int lat, nst, a0, e0, r0, q0;

    tbl.push_back(mk(0, R+0, 0, 4'hF, 0, ACK, 1));
    tbl.push_back(mk(0, R+2, 0, 4'hF, 0, ACK, 32'hF));
    tbl.push_back(mk(0, R+4, 0, 4'hF, 0, ACK, 32'hFF));
    tbl.push_back(mk(0, R+3, 0, 4'hF, 0, ACK, 0));
    tbl.push_back(mk(0, R+1, 0, 4'hF, 0, ACK, 0));
    tbl.push_back(mk(1, R+0, 3, 4'h1, 0, ACK, 0));
    tbl.push_back(mk(0, R+0, 0, 4'hF, 0, ACK, 3));
    tbl.push_back(mk(1, R+0, 5, 4'h0, 0, ACK, 0));
    tbl.push_back(mk(0, R+0, 0, 4'hF, 0, ACK, 3));
    tbl.push_back(mk(1, R+4, 7, 4'h2, 0, ACK, 0));
    tbl.push_back(mk(0, R+4, 0, 4'hF, 0, ACK, 32'hFF));
    tbl.push_back(mk(1, R+4, 32'hA40, 4'h1, 0, ACK, 0));
    tbl.push_back(mk(0, R+4, 0, 4'hF, 0, ACK, 32'h40));
    tbl.push_back(mk(1, R+4, 32'hFF, 4'h1, 0, ACK, 0));
    tbl.push_back(mk(0, R+7, 0, 4'hF, 0, ERR, 0));
    tbl.push_back(mk(0, R+5, 0, 4'hF, 0, ERR, 0));
    tbl.push_back(mk(1, BASE-1, 0, 4'hF, 0, ERR, 0));
    tbl.push_back(mk(0, R+3, 0, 4'hF, 0, ACK, 3));
    tbl.push_back(mk(0, R+1, 0, 4'hF, 0, ACK, 2));
    tbl.push_back(mk(1, R+1, 0, 4'h0, 0, ACK, 0));
    tbl.push_back(mk(1, R+3, 0, 4'h0, 0, ACK, 0));
    tbl.push_back(mk(0, R+1, 0, 4'hF, 0, ACK, 0));
    tbl.push_back(mk(0, R+1, 0, 4'hF, 1, ACK, 4));
    tbl.push_back(mk(0, R+3, 0, 4'hF, 0, ACK, 0));
    tbl.push_back(mk(1, R+2, 5, 4'h1, 0, ACK, 0));
    tbl.push_back(mk(0, R+2, 0, 4'hF, 0, ACK, 5));
    tbl.push_back(mk(1, R+2, 32'hFF, 4'h1, 0, ACK, 0));
    tbl.push_back(mk(0, R+2, 0, 4'hF, 0, ACK, 32'hF));

    repeat (3) tick();
    rst = 0;
    tick();
    check("rst ack", ack, 0);
    check("rst err", err, 0);
    check("rst rty", rty, 0);
    check("rst stall", stall, 0);
    check("rst req", core_req, 0);
    check("rst dat", dato, 0);
    check("rst adr", core_adr, 0);
    check("rst raid", raid_type, 1);
    check("rst chan", chan_en, 4'hF);

    last = '0;
    foreach (tbl[i]) begin
      par = tbl[i].par;
      bus(tbl[i].we, tbl[i].adr, tbl[i].dat,
          tbl[i].sel, rsp, rd, lat, nst);
      par = 0;
      check($sformatf("v%0d rsp", i), rsp,
            tbl[i].rsp);
      check($sformatf("v%0d lat", i), lat, 1);
      check($sformatf("v%0d stall", i), nst, 0);
      if (tbl[i].rsp == ACK && !tbl[i].we) begin
        check($sformatf("v%0d rdat", i), rd,
              tbl[i].rdat);
        last = tbl[i].rdat;
      end else begin
        check($sformatf("v%0d hold", i), rd,
              last);
      end
    end
    check("raid_type_o", raid_type, 3);

    // read through the core, grant then done
    a0 = n_ack;
    fork
      bus(0, BASE+5, 0, 4'hF, rsp, rd, lat, nst);
      core_resp(1, 3, 1, 32'hDEADBEEF, 0,
                0, 10'd5, 0, 4'hF);
    join
    check("mrd rsp", rsp, ACK);
    check("mrd dat", rd, 32'hDEADBEEF);
    check("mrd lat", lat, 7);
    check("mrd stall", nst, 0);
    check("mrd acks", n_ack - a0, 1);

    // done coincides with timeout: done wins
    bus(1, R+4, 2, 4'h1, rsp, rd, lat, nst);
    fork
      bus(0, BASE+9, 0, 4'hF, rsp, rd, lat, nst);
      core_resp(0, 2, 1, 32'hCAFE0001, 0,
                0, 10'd9, 0, 4'hF);
    join
    check("tie rsp", rsp, ACK);
    check("tie dat", rd, 32'hCAFE0001);
    check("tie lat", lat, 5);

    // core reports an error
    fork
      bus(1, BASE+32'h3FF, 32'h11112222, 4'hC,
          rsp, rd, lat, nst);
      core_resp(0, 1, 1, 0, 1,
                1, 10'h3FF, 32'h11112222, 4'hC);
    join
    check("cerr rsp", rsp, ERR);
    check("cerr lat", lat, 4);
    bus(0, R+3, 0, 4'hF, rsp, rd, lat, nst);
    check("cerr cnt", rd, 1);
    bus(0, R+1, 0, 4'hF, rsp, rd, lat, nst);
    check("cerr status", rd, 2);
    bus(1, R+3, 0, 4'hF, rsp, rd, lat, nst);
    bus(1, R+1, 0, 4'hF, rsp, rd, lat, nst);

    // timeout with TMO=3, core never finishes
    bus(1, R+4, 3, 4'h1, rsp, rd, lat, nst);
    busy = 1;
    fork
      bus(1, BASE+16, 32'h12345678, 4'hF,
          rsp, rd, lat, nst);
      core_resp(0, 0, 0, 0, 0,
                1, 10'd16, 32'h12345678, 4'hF);
    join
    check("tmo rsp", rsp, ERR);
    check("tmo lat", lat, 6);
    check("tmo stall", nst, 0);
    bus(0, R+1, 0, 4'hF, rsp, rd, lat, nst);
    check("tmo status", rd, 32'hB);
    busy = 0;
    bus(0, R+3, 0, 4'hF, rsp, rd, lat, nst);
    check("tmo errcnt", rd, 1);

    // all channels disabled: retry, no core req
    bus(1, R+2, 0, 4'h1, rsp, rd, lat, nst);
    check("chan off", chan_en, 0);
    q0 = n_req; r0 = n_rty;
    bus(0, BASE+5, 0, 4'hF, rsp, rd, lat, nst);
    check("rty rsp", rsp, RTY);
    check("rty lat", lat, 1);
    check("rty pulses", n_rty - r0, 1);
    check("rty no req", n_req - q0, 0);
    bus(0, R+7, 0, 4'hF, rsp, rd, lat, nst);
    check("r7 rsp", rsp, ERR);
    bus(1, R+2, 32'hF, 4'h1, rsp, rd, lat, nst);
    bus(1, R+4, 32'hFF, 4'h1, rsp, rd, lat, nst);

    // master abandons the cycle during WAIT
    a0 = n_ack; e0 = n_err;
    cyc = 1; stb = 1; we = 0;
    adr = BASE + 3; sel = 4'hF;
    tick();
    check("drop req", core_req, 1);
    gnt = 1;
    tick();
    gnt = 0;
    cyc = 0; stb = 0;
    repeat (2) tick();
    check("drop wait stall", stall, 1);
    done = 1; cdat = 32'h55AA55AA;
    tick();
    done = 0;
    check("drop idle", stall, 0);
    tick();
    check("drop no ack", n_ack - a0, 0);
    check("drop no err", n_err - e0, 0);
    bus(0, R+3, 0, 4'hF, rsp, rd, lat, nst);
    check("drop rd rsp", rsp, ACK);
    check("drop rd lat", lat, 1);
    check("drop errcnt", rd, 2);

    // reset while waiting on the core
    cyc = 1; stb = 1; we = 1;
    adr = BASE + 7; wdat = 32'hA5A5A5A5;
    sel = 4'h3;
    tick();
    gnt = 1;
    tick();
    gnt = 0;
    tick();
    rst = 1;
    #1;
    check("ar ack", ack, 0);
    check("ar err", err, 0);
    check("ar stall", stall, 0);
    check("ar req", core_req, 0);
    check("ar core_we", core_we, 0);
    check("ar core_adr", core_adr, 0);
    check("ar core_dat", core_dat, 0);
    check("ar core_sel", core_sel, 0);
    check("ar dat", dato, 0);
    check("ar raid", raid_type, 1);
    check("ar chan", chan_en, 4'hF);
    cyc = 0; stb = 0; we = 0;
    a0 = n_ack; e0 = n_err;
    tick();
    rst = 0;
    done = 1;
    tick();
    done = 0;
    repeat (3) tick();
    check("ar no ack", n_ack - a0, 0);
    check("ar no err", n_err - e0, 0);
    bus(0, R+3, 0, 4'hF, rsp, rd, lat, nst);
    check("ar errcnt", rd, 0);
    bus(0, R+4, 0, 4'hF, rsp, rd, lat, nst);
    check("ar tmo", rd, 32'hFF);
    bus(0, R+1, 0, 4'hF, rsp, rd, lat, nst);
    check("ar status", rd, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
